// File: rtl/seq_signed_divider_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seq_signed_divider_pkg
// Description : Shared definitions for the sequential signed divider.
//               - Controller state encodings (2-bit).
//               - Iteration-counter width helper, clog2(N+1).
// Revision    : 1.0  initial release
// ============================================================================
package seq_signed_divider_pkg;

    localparam int c_STATE_W = 2;

    localparam logic [c_STATE_W-1:0] c_IDLE    = 2'd0;
    localparam logic [c_STATE_W-1:0] c_CALC    = 2'd1;
    localparam logic [c_STATE_W-1:0] c_FIXUP   = 2'd2;
    localparam logic [c_STATE_W-1:0] c_SPECIAL = 2'd3;

    // Width of the iteration counter for an n-bit divide.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_signed_divider_ripple_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : ripple_subtractor
// Description : Combinational W-bit subtractor, Diff = A + ~B + 1, built as a
//               ripple chain of full adders.
// Ports       : A, B    W-bit operands
//               Diff    W-bit difference
//               Borrow  high when A < B (inverted carry-out)
// Revision    : 1.0  initial release
// ============================================================================
module ripple_subtractor #(
    parameter int W = 33
) (
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    output logic [W-1:0] Diff,
    output logic         Borrow
);

    logic [W:0] w_carry;

    // Carry-in of 1 completes the two's-complement of B.
    assign w_carry[0] = 1'b1;

    generate
        for (genvar i = 0; i < W; i++) begin : g_bit
            logic w_b_inv;
            assign w_b_inv        = ~B[i];
            assign Diff[i]        = A[i] ^ w_b_inv ^ w_carry[i];
            assign w_carry[i + 1] = (A[i] & w_b_inv) | (w_carry[i] & (A[i] ^ w_b_inv));
        end
    endgenerate

    assign Borrow = ~w_carry[W];

endmodule
`default_nettype wire

// File: rtl/seq_signed_divider.sv
`default_nettype none
// ============================================================================
// Module      : seq_signed_divider
// Description : Multi-cycle signed restoring divider, one quotient bit per
//               cycle. Quotient truncates toward zero, remainder takes the
//               sign of the dividend. Divide-by-zero and MIN_INT/-1 are
//               resolved in a single SPECIAL cycle.
// Ports       : clk, rst            clock, asynchronous active-high reset
//               start               request, sampled only in IDLE
//               Dividend, Divisor   N-bit signed operands
//               Quotient, Remainder N-bit signed results (held until next done)
//               busy                operation in progress
//               done                one-cycle result-valid pulse
//               DivByZero, Overflow status of the last completed operation
// Revision    : 1.0  initial release
// ============================================================================
module seq_signed_divider
    import seq_signed_divider_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] Dividend,
    input  logic [N-1:0] Divisor,
    output logic [N-1:0] Quotient,
    output logic [N-1:0] Remainder,
    output logic         busy,
    output logic         done,
    output logic         DivByZero,
    output logic         Overflow
);

    localparam int              c_CW       = cnt_width(N);
    localparam logic [N-1:0]    c_MIN_INT  = {1'b1, {(N-1){1'b0}}};
    localparam logic [N-1:0]    c_ALL_ONES = {N{1'b1}};
    localparam logic [c_CW-1:0] c_LAST     = c_CW'(N - 1);

    logic [c_STATE_W-1:0] r_state;
    logic [c_STATE_W-1:0] w_state_next;

    logic [N-1:0]    r_rem;       // committed partial remainder (always < divisor)
    logic [N-1:0]    r_quo;       // dividend magnitude shifting out, quotient shifting in
    logic [N-1:0]    r_dvs;       // divisor magnitude
    logic [c_CW-1:0] r_cnt;
    logic            r_neg_q;
    logic            r_neg_r;
    logic            r_dbz_case;

    logic [N-1:0]    r_quotient;
    logic [N-1:0]    r_remainder;
    logic            r_busy;
    logic            r_done;
    logic            r_dbz;
    logic            r_ovf;

    logic            w_special;
    logic [N-1:0]    w_dvd_abs;
    logic [N-1:0]    w_dvs_abs;
    logic [N:0]      w_shift;
    logic [N:0]      w_diff;
    logic            w_borrow;
    logic            w_take;
    logic [N-1:0]    w_q_fix;
    logic [N-1:0]    w_r_fix;

    assign w_special = (Divisor == '0) ||
                       ((Dividend == c_MIN_INT) && (Divisor == c_ALL_ONES));

    // |MIN_INT| wraps to the MIN_INT bit pattern, which read as unsigned is
    // exactly 2^(N-1), so the magnitudes fit in N unsigned bits.
    assign w_dvd_abs = Dividend[N-1] ? (~Dividend + 1'b1) : Dividend;
    assign w_dvs_abs = Divisor[N-1]  ? (~Divisor  + 1'b1) : Divisor;

    // N+1-bit shifted partial remainder for this iteration.
    assign w_shift = {r_rem, r_quo[N-1]};

    ripple_subtractor #(
        .W (N + 1)
    ) u_trial_sub (
        .A      (w_shift),
        .B      ({1'b0, r_dvs}),
        .Diff   (w_diff),
        .Borrow (w_borrow)
    );

    // Trial difference is non-negative: no borrow and a clear sign bit.
    assign w_take = ~w_borrow & ~w_diff[N];

    assign w_q_fix = r_neg_q ? (~r_quo + 1'b1) : r_quo;
    assign w_r_fix = r_neg_r ? (~r_rem + 1'b1) : r_rem;

    // ------------------------------------------------------------------
    // Controller
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (start) begin
                    w_state_next = w_special ? c_SPECIAL : c_CALC;
                end
            end
            c_CALC: begin
                if (r_cnt == c_LAST) begin
                    w_state_next = c_FIXUP;
                end
            end
            c_FIXUP:   w_state_next = c_IDLE;
            c_SPECIAL: w_state_next = c_IDLE;
            default:   w_state_next = c_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rem       <= '0;
            r_quo       <= '0;
            r_dvs       <= '0;
            r_cnt       <= '0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            r_dbz_case  <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_dbz       <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_busy     <= 1'b1;
                        r_cnt      <= '0;
                        r_rem      <= '0;
                        r_neg_q    <= Dividend[N-1] ^ Divisor[N-1];
                        r_neg_r    <= Dividend[N-1];
                        r_dbz_case <= (Divisor == '0);
                        r_dvs      <= w_dvs_abs;
                        // Special cases keep the raw dividend: divide-by-zero
                        // returns it unchanged as the remainder.
                        r_quo      <= w_special ? Dividend : w_dvd_abs;
                    end
                end
                c_CALC: begin
                    r_rem <= w_take ? w_diff[N-1:0] : w_shift[N-1:0];
                    r_quo <= {r_quo[N-2:0], w_take};
                    r_cnt <= r_cnt + c_CW'(1);
                end
                c_FIXUP: begin
                    r_quotient  <= w_q_fix;
                    r_remainder <= w_r_fix;
                    r_dbz       <= 1'b0;
                    r_ovf       <= 1'b0;
                    r_busy      <= 1'b0;
                    r_done      <= 1'b1;
                end
                c_SPECIAL: begin
                    if (r_dbz_case) begin
                        r_quotient  <= c_ALL_ONES;
                        r_remainder <= r_quo;
                        r_dbz       <= 1'b1;
                        r_ovf       <= 1'b0;
                    end else begin
                        r_quotient  <= c_MIN_INT;
                        r_remainder <= '0;
                        r_dbz       <= 1'b0;
                        r_ovf       <= 1'b1;
                    end
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
                default: begin
                    r_busy <= 1'b0;
                end
            endcase
        end
    end

    assign Quotient  = r_quotient;
    assign Remainder = r_remainder;
    assign busy      = r_busy;
    assign done      = r_done;
    assign DivByZero = r_dbz;
    assign Overflow  = r_ovf;

endmodule
`default_nettype wire
